lc3b_mem_responder: RTL and testbench
=====================================

Name: lc3b_mem_responder

Overview:
- Memory-side responder for the LC-3b CPU memory interface. It answers `mem_read`/`mem_write` requests from the CPU with a programmable-latency, single-cycle `mem_resp` pulse.
- It holds a word-organised RAM, applies the 2-bit byte write mask, and returns registered read data.
- It sits beside the `cpu` top level in testbenches and in the simple-system top. It also has a preload port so a bench can write a program image into the RAM.

Parameters:
- ADDR_BITS, 15, number of word-index bits. Depth is 2^ADDR_BITS 16-bit words; byte-address bits above ADDR_BITS are ignored, so addresses alias.
- LATENCY, 3, cycles from request acceptance to `mem_resp`. Legal range is 1..15.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  synchronous, active-high reset.
- mem_read  in  1  read request; held by the CPU until `mem_resp`.
- mem_write  in  1  write request; held by the CPU until `mem_resp`.
- mem_byte_enable  in  2  write mask: bit0 covers data[7:0], bit1 covers data[15:8].
- mem_address  in  16  byte address; bit 0 is ignored, and the word index is `mem_address[ADDR_BITS:1]`.
- mem_wdata  in  16  write data.
- mem_resp  out  1  one-cycle completion pulse.
- mem_rdata  out  16  read data; valid during the `mem_resp` cycle and held until the next read response.
- proto_err  out  1  one-cycle pulse on a protocol violation.
- preload_en  in  1  backdoor word write (bench use).
- preload_addr  in  ADDR_BITS  backdoor word index.
- preload_data  in  16  backdoor write data.

Behaviour:
- Reset: state becomes IDLE, `mem_resp`=0, `mem_rdata`=0, `proto_err`=0, latency counter=0. RAM contents are not cleared. A reset during BUSY abandons the access: no write commits and no `mem_resp` is issued.
- FSM states are IDLE, BUSY, RESP.
- IDLE:
  - If (`mem_read` | `mem_write`) is sampled high, latch op, word index, mask and wdata, load the counter with LATENCY-1, then go to BUSY (or straight to RESP if LATENCY=1).
  - If both `mem_read` and `mem_write` are high, pulse `proto_err` in the next cycle and treat the request as a write.
- BUSY:
  - Decrement the counter each cycle and go to RESP when it reaches 0.
  - If both requests drop while in BUSY, abort: pulse `proto_err`, return to IDLE, no write, no `mem_resp`.
  - Address or data changes in BUSY are ignored; the latched values are used.
- RESP:
  - `mem_resp`=1 for exactly this cycle.
  - Read: `mem_rdata` = RAM[latched index], captured on the edge entering RESP.
  - Write: the selected bytes are committed to RAM on the edge leaving RESP. A mask of 2'b00 commits nothing but still responds.
  - Next state is IDLE.
- Latency: a request first seen in cycle t gets `mem_resp` in cycle t+LATENCY.
- Back-to-back: IDLE accepts a new request in the cycle immediately after RESP, so the minimum request spacing is LATENCY+1 cycles.
- Preload:
  - `preload_en` writes the full word `preload_data` to RAM[`preload_addr`] on the edge, in any state including during reset.
  - If it hits the same word as a CPU write commit on the same edge, the CPU write wins on its enabled bytes and preload supplies the other bytes.
  - A preload to a word being read in BUSY is visible to that read when it lands before the RESP capture edge.
- Read-after-write: a read accepted right after a write response sees the committed data.

Test Plan:
- Preload word 0x0010 with 0x1234, LATENCY=3; read `mem_address`=0x0020 asserted at cycle 0 -> `mem_resp`=1 only at cycle 3, `mem_rdata`=0x1234, and `mem_rdata` is still 0x1234 at cycle 6.
- Preload word 0x0010 with 0x1234; write 0xABCD to 0x0020 with mask 2'b01, then read 0x0021 -> `mem_rdata`=0x12CD. Then mask 2'b10 with 0x5600, read -> 0x56CD. Mask 2'b00 -> `mem_resp` occurs and the data is unchanged.
- Assert `mem_read` and `mem_write` together -> `proto_err` pulses one cycle after acceptance and a write occurs. Separately, drop `mem_read` mid-BUSY -> `proto_err` pulses, no `mem_resp`, and the FSM is back in IDLE.
- Issue `rst` in the second BUSY cycle of a write of 0xFFFF to 0x0040 (word 0x0020 holds 0x0000) -> no `mem_resp`, `mem_rdata`=0, and a later read of 0x0040 returns 0x0000.
- LATENCY=1 with 4 back-to-back reads of words 0..3 preloaded with 0xA0..0xA3 -> responses at cycles 1, 3, 5, 7 with the matching data.
- Address aliasing with ADDR_BITS=4: write 0x7777 to 0x0002, read 0x0022 -> `mem_rdata`=0x7777.

Source files
------------

// File: rtl/lc3b_mem_responder_if.sv
// LC-3b CPU memory bus: request/response handshake between the CPU (master)
// and the memory responder (slave).
interface lc3b_mem_responder_if;
    logic        mem_read;
    logic        mem_write;
    logic [1:0]  mem_byte_enable;
    logic [15:0] mem_address;
    logic [15:0] mem_wdata;
    logic        mem_resp;
    logic [15:0] mem_rdata;
    logic        proto_err;

    modport master (
        output mem_read, mem_write, mem_byte_enable, mem_address, mem_wdata,
        input  mem_resp, mem_rdata, proto_err
    );

    modport slave (
        input  mem_read, mem_write, mem_byte_enable, mem_address, mem_wdata,
        output mem_resp, mem_rdata, proto_err
    );
endinterface

// File: rtl/lc3b_mem_responder.sv
// Memory-side responder for the LC-3b CPU. Accepts one read or write at a
// time, answers after a fixed latency with a one-cycle mem_resp pulse, and
// keeps a word-organised RAM split into two byte lanes so the byte-enable
// mask maps onto independent lane writes. A backdoor preload port lets a
// bench drop a program image into the RAM in any state.
module lc3b_mem_responder #(
    parameter int ADDR_BITS = 15,
    parameter int LATENCY   = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    lc3b_mem_responder_if.slave  mem,
    input  logic                 preload_en,
    input  logic [ADDR_BITS-1:0] preload_addr,
    input  logic [15:0]          preload_data
);
    localparam int DEPTH = 1 << ADDR_BITS;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic [3:0]             cnt_q, cnt_d;
    logic                   is_write_q, is_write_d;
    logic [ADDR_BITS-1:0]   idx_q, idx_d;
    logic [1:0]             be_q, be_d;
    logic [15:0]            wdata_q, wdata_d;
    logic                   proto_err_q, proto_err_d;

    logic                   req;
    logic [ADDR_BITS-1:0]   bus_idx;
    logic [ADDR_BITS-1:0]   rd_idx;
    logic                   rd_capture;
    logic                   commit;
    logic [15:0]            rdata_lanes;

    assign req     = mem.mem_read | mem.mem_write;
    assign bus_idx = mem.mem_address[ADDR_BITS:1];

    // Next-state, request latching and RAM strobe decode.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        is_write_d  = is_write_q;
        idx_d       = idx_q;
        be_d        = be_q;
        wdata_d     = wdata_q;
        proto_err_d = 1'b0;
        rd_capture  = 1'b0;
        commit      = 1'b0;
        rd_idx      = idx_q;

        case (state_q)
            IDLE: begin
                // With LATENCY=1 the read is captured straight off the bus.
                rd_idx = bus_idx;
                if (req) begin
                    // Simultaneous read+write is flagged and treated as a write.
                    is_write_d  = mem.mem_write;
                    idx_d       = bus_idx;
                    be_d        = mem.mem_byte_enable;
                    wdata_d     = mem.mem_wdata;
                    proto_err_d = mem.mem_read & mem.mem_write;
                    if (LATENCY <= 1) begin
                        state_d    = RESP;
                        cnt_d      = 4'd0;
                        rd_capture = ~mem.mem_write;
                    end else begin
                        state_d    = BUSY;
                        cnt_d      = 4'(LATENCY - 1);
                    end
                end
            end
            BUSY: begin
                if (!req) begin
                    // CPU withdrew the request: abandon without responding.
                    state_d     = IDLE;
                    cnt_d       = 4'd0;
                    proto_err_d = 1'b1;
                end else if (cnt_q <= 4'd1) begin
                    state_d    = RESP;
                    cnt_d      = 4'd0;
                    rd_capture = ~is_write_q;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESP: begin
                state_d = IDLE;
                commit  = is_write_q;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Control state register; reset abandons any access in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= 4'd0;
            is_write_q  <= 1'b0;
            idx_q       <= '0;
            be_q        <= 2'b00;
            wdata_q     <= 16'h0000;
            proto_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            is_write_q  <= is_write_d;
            idx_q       <= idx_d;
            be_q        <= be_d;
            wdata_q     <= wdata_d;
            proto_err_q <= proto_err_d;
        end
    end

    // One RAM per byte lane so the write mask is a per-lane write enable.
    for (genvar gi = 0; gi < 2; gi++) begin : g_lane
        logic [7:0] ram_q [DEPTH];
        logic [7:0] rdata_q;

        // Preload first, CPU commit second: on a same-word collision the CPU
        // byte overrides the preload byte only on its enabled lanes.
        always_ff @(posedge clk) begin
            if (preload_en) begin
                ram_q[preload_addr] <= preload_data[gi*8 +: 8];
            end
            if (commit && be_q[gi] && !rst) begin
                ram_q[idx_q] <= wdata_q[gi*8 +: 8];
            end
        end

        // Registered read, updated only on the edge entering a read response.
        always_ff @(posedge clk) begin
            if (rst) begin
                rdata_q <= 8'h00;
            end else if (rd_capture) begin
                rdata_q <= ram_q[rd_idx];
            end
        end

        assign rdata_lanes[gi*8 +: 8] = rdata_q;
    end

    assign mem.mem_resp  = (state_q == RESP);
    assign mem.mem_rdata = rdata_lanes;
    assign mem.proto_err = proto_err_q;
endmodule

// File: tb/tb_lc3b_mem_responder.sv
// Directed bench for lc3b_mem_responder. Three instances: default
// (LATENCY=3), LATENCY=1 for back-to-back spacing, and ADDR_BITS=4 for
// address aliasing. Shared stimulus is steered to one instance by sel.
module tb_lc3b_mem_responder;
    logic        clk = 1'b0;
    logic        rst;
    int          cyc = 0;
    int          checks = 0;
    int          failures = 0;

    logic        read_s, write_s;
    logic [1:0]  be_s;
    logic [15:0] addr_s, wdata_s;
    int          sel;
    logic        pl_en_s;
    logic [14:0] pl_addr_s;
    logic [15:0] pl_data_s;

    logic        resp_w [3];
    logic [15:0] rdata_w [3];
    logic        perr_w [3];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    for (genvar gi = 0; gi < 3; gi++) begin : g_dut
        localparam int AB = (gi == 2) ? 4 : 15;
        localparam int LT = (gi == 1) ? 1 : 3;
        lc3b_mem_responder_if bus ();
        assign bus.mem_read        = read_s && (sel == gi);
        assign bus.mem_write       = write_s && (sel == gi);
        assign bus.mem_byte_enable = be_s;
        assign bus.mem_address     = addr_s;
        assign bus.mem_wdata       = wdata_s;
        assign resp_w[gi]          = bus.mem_resp;
        assign rdata_w[gi]         = bus.mem_rdata;
        assign perr_w[gi]          = bus.proto_err;

        lc3b_mem_responder #(.ADDR_BITS(AB), .LATENCY(LT)) dut (
            .clk          (clk),
            .rst          (rst),
            .mem          (bus),
            .preload_en   (pl_en_s && (sel == gi)),
            .preload_addr (pl_addr_s[AB-1:0]),
            .preload_data (pl_data_s)
        );
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic preload(input int s, input logic [14:0] a, input logic [15:0] d);
        sel = s; pl_en_s = 1'b1; pl_addr_s = a; pl_data_s = d;
        next_cycle();
        pl_en_s = 1'b0;
    endtask

    // Issue one request (starting in the current cycle) and hold it until
    // mem_resp; reports the relative and absolute response cycle.
    task automatic cpu_access(input int s, input logic rd, input logic wr,
                              input logic [1:0] be, input logic [15:0] addr,
                              input logic [15:0] wd, output int rel, output int abs_c,
                              output logic [15:0] rdat, output int nperr, output int perr_c);
        rel = -1; abs_c = -1; rdat = 16'hxxxx; nperr = 0; perr_c = -1;
        sel = s; read_s = rd; write_s = wr; be_s = be; addr_s = addr; wdata_s = wd;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (perr_w[s]) begin
                nperr++;
                if (perr_c < 0) perr_c = c;
            end
            if (resp_w[s]) begin
                rel = c; abs_c = cyc; rdat = rdata_w[s];
                read_s = 1'b0; write_s = 1'b0;
            end
            next_cycle();
            if (rel >= 0) break;
        end
        read_s = 1'b0; write_s = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        next_cycle();
        preload(0, 15'h0010, 16'h1234);
        preload(0, 15'h0018, 16'h0000);
        preload(0, 15'h0020, 16'h0000);
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (resp_w[i] !== 1'b0 || rdata_w[i] !== 16'h0000 || perr_w[i] !== 1'b0) begin
                failures++;
                $display("FAIL reset dut%0d: got resp=%b rdata=%h perr=%b expected 0/0000/0",
                         i, resp_w[i], rdata_w[i], perr_w[i]);
            end
        end
        next_cycle();
        rst = 1'b0;
        $display("test_reset: outputs checked under reset");
    endtask

    task automatic test_read_latency();
        sel = 0; read_s = 1'b1; addr_s = 16'h0020; be_s = 2'b00; wdata_s = 16'h0000;
        for (int c = 0; c < 7; c++) begin
            @(negedge clk);
            checks++;
            if (resp_w[0] !== (c == 3)) begin
                failures++;
                $display("FAIL read_latency resp c%0d: got %b expected %b", c, resp_w[0], (c == 3));
            end
            if (c == 3 || c == 6) begin
                checks++;
                if (rdata_w[0] !== 16'h1234) begin
                    failures++;
                    $display("FAIL read_latency rdata c%0d: got %h expected 1234", c, rdata_w[0]);
                end
                read_s = 1'b0;
            end
            next_cycle();
        end
        $display("test_read_latency: read 0x0020 -> rdata=%h", rdata_w[0]);
    endtask

    task automatic test_byte_mask();
        int rel, ab, np, pc;
        logic [15:0] rd;
        logic [15:0] exp_v [3] = '{16'h12CD, 16'h56CD, 16'h56CD};
        logic [1:0]  mask_v [3] = '{2'b01, 2'b10, 2'b00};
        logic [15:0] wd_v [3] = '{16'hABCD, 16'h5600, 16'hFFFF};
        for (int i = 0; i < 3; i++) begin
            cpu_access(0, 1'b0, 1'b1, mask_v[i], 16'h0020, wd_v[i], rel, ab, rd, np, pc);
            checks++;
            if (rel !== 3) begin
                failures++;
                $display("FAIL byte_mask write%0d resp cycle: got %0d expected 3", i, rel);
            end
            cpu_access(0, 1'b1, 1'b0, 2'b00, 16'h0021, 16'h0000, rel, ab, rd, np, pc);
            checks++;
            if (rd !== exp_v[i]) begin
                failures++;
                $display("FAIL byte_mask read%0d: got %h expected %h", i, rd, exp_v[i]);
            end
            $display("test_byte_mask: mask=%b wdata=%h -> read %h", mask_v[i], wd_v[i], rd);
        end
    endtask

    task automatic test_proto_err();
        int rel, ab, np, pc;
        logic [15:0] rd;
        cpu_access(0, 1'b1, 1'b1, 2'b11, 16'h0030, 16'h0F0F, rel, ab, rd, np, pc);
        checks++;
        if (np !== 1 || pc !== 1 || rel !== 3) begin
            failures++;
            $display("FAIL proto_both: got perr_count=%0d perr_cycle=%0d resp=%0d expected 1/1/3", np, pc, rel);
        end
        cpu_access(0, 1'b1, 1'b0, 2'b00, 16'h0030, 16'h0000, rel, ab, rd, np, pc);
        checks++;
        if (rd !== 16'h0F0F) begin
            failures++;
            $display("FAIL proto_both write data: got %h expected 0f0f", rd);
        end
        $display("test_proto_err: both-high write -> read %h", rd);

        // Abort: drop mem_read in the first BUSY cycle.
        np = 0;
        sel = 0; read_s = 1'b1; addr_s = 16'h0020;
        next_cycle();
        read_s = 1'b0;
        for (int c = 1; c < 7; c++) begin
            @(negedge clk);
            if (perr_w[0]) np++;
            checks++;
            if (resp_w[0] !== 1'b0) begin
                failures++;
                $display("FAIL abort resp c%0d: got %b expected 0", c, resp_w[0]);
            end
            next_cycle();
        end
        checks++;
        if (np !== 1) begin
            failures++;
            $display("FAIL abort perr count: got %0d expected 1", np);
        end
        cpu_access(0, 1'b1, 1'b0, 2'b00, 16'h0020, 16'h0000, rel, ab, rd, np, pc);
        checks++;
        if (rel !== 3 || rd !== 16'h56CD) begin
            failures++;
            $display("FAIL abort idle: got resp=%0d rdata=%h expected 3/56cd", rel, rd);
        end
        $display("test_proto_err: abort then read -> %h", rd);
    endtask

    task automatic test_reset_busy();
        int rel, ab, np, pc;
        logic [15:0] rd;
        sel = 0; write_s = 1'b1; be_s = 2'b11; addr_s = 16'h0040; wdata_s = 16'hFFFF;
        next_cycle();
        next_cycle();
        rst = 1'b1;
        for (int c = 2; c < 7; c++) begin
            @(negedge clk);
            checks++;
            if (resp_w[0] !== 1'b0) begin
                failures++;
                $display("FAIL reset_busy resp c%0d: got %b expected 0", c, resp_w[0]);
            end
            if (c == 3) begin
                checks++;
                if (rdata_w[0] !== 16'h0000) begin
                    failures++;
                    $display("FAIL reset_busy rdata: got %h expected 0000", rdata_w[0]);
                end
            end
            next_cycle();
            if (c == 2) begin
                rst = 1'b0;
                write_s = 1'b0;
            end
        end
        cpu_access(0, 1'b1, 1'b0, 2'b00, 16'h0040, 16'h0000, rel, ab, rd, np, pc);
        checks++;
        if (rel !== 3 || rd !== 16'h0000) begin
            failures++;
            $display("FAIL reset_busy readback: got resp=%0d rdata=%h expected 3/0000", rel, rd);
        end
        $display("test_reset_busy: reset mid-write, readback %h", rd);
    endtask

    task automatic test_back_to_back();
        int rel, ab, np, pc, base;
        logic [15:0] rd;
        for (int i = 0; i < 4; i++) preload(1, 15'(i), 16'h00A0 + 16'(i));
        base = cyc;
        for (int i = 0; i < 4; i++) begin
            cpu_access(1, 1'b1, 1'b0, 2'b00, 16'(2 * i), 16'h0000, rel, ab, rd, np, pc);
            checks++;
            if ((ab - base) !== (2 * i + 1) || rd !== 16'h00A0 + 16'(i)) begin
                failures++;
                $display("FAIL back_to_back %0d: got cycle=%0d rdata=%h expected %0d/%h",
                         i, ab - base, rd, 2 * i + 1, 16'h00A0 + 16'(i));
            end
            $display("test_back_to_back: read word %0d at cycle %0d -> %h", i, ab - base, rd);
        end
    endtask

    task automatic test_alias();
        int rel, ab, np, pc;
        logic [15:0] rd;
        cpu_access(2, 1'b0, 1'b1, 2'b11, 16'h0002, 16'h7777, rel, ab, rd, np, pc);
        cpu_access(2, 1'b1, 1'b0, 2'b00, 16'h0022, 16'h0000, rel, ab, rd, np, pc);
        checks++;
        if (rd !== 16'h7777) begin
            failures++;
            $display("FAIL alias: got %h expected 7777", rd);
        end
        $display("test_alias: write 0x0002, read 0x0022 -> %h", rd);
    endtask

    initial begin
        rst = 1'b1; sel = 0; read_s = 1'b0; write_s = 1'b0; be_s = 2'b00;
        addr_s = 16'h0000; wdata_s = 16'h0000;
        pl_en_s = 1'b0; pl_addr_s = 15'h0000; pl_data_s = 16'h0000;
        #1;
        test_reset();
        test_read_latency();
        test_byte_mask();
        test_proto_err();
        test_reset_busy();
        test_back_to_back();
        test_alias();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
